// File: rtl/mps_pkg.sv
// Shared definitions for the microprogrammed sequencer/datapath slice:
// ALU function encoding and register-file geometry.
package mps_pkg;

  localparam int RF_DEPTH = 8;
  localparam int RF_IDX_W = 3;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

endpackage

// File: rtl/datapath_alu.sv
// Combinational 4-function ALU with one extra bit of internal sum for the carry.
// For SUB the carry is the no-borrow indication (a >= b unsigned).
module alu
  import mps_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] r,
  output logic              c
);

  logic [DATA_W:0] w_sum;
  alu_op_t         w_op;

  assign w_op = alu_op_t'(op);

  always_comb begin
    w_sum = '0;
    case (w_op)
      ALU_ADD: w_sum = {1'b0, a} + {1'b0, b};
      ALU_SUB: w_sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
      ALU_AND: w_sum = {1'b0, a & b};
      ALU_OR:  w_sum = {1'b0, a | b};
      default: w_sum = '0;
    endcase
  end

  assign r = w_sum[DATA_W-1:0];
  assign c = w_sum[DATA_W];

endmodule

// File: rtl/datapath.sv
// Register-file datapath: 8-entry RF (entry 0 hard-wired to zero), R_in, R_out,
// ALU and the cy/neg/zero flags fed back to the sequencer for branching.
module datapath
  import mps_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RF_IDX_W-1:0] fld_A,
  input  logic [RF_IDX_W-1:0] fld_B,
  input  logic [RF_IDX_W-1:0] fld_C,
  input  logic                ldRF,
  input  logic                selR_in,
  input  logic                ldR_in,
  input  logic                ldR_out,
  input  logic [1:0]          alu_op,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                cy,
  output logic                neg,
  output logic                zero
);

  logic [DATA_W-1:0] w_rf [RF_DEPTH];
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_r;
  logic              w_c;
  logic              w_capture;

  logic [DATA_W-1:0] r_rin;
  logic [DATA_W-1:0] r_rout;
  logic              r_cy;
  logic              r_neg;
  logic              r_zero;

  assign w_rf[0] = '0;

  // Entries 1..7 are plain flops so that both read ports stay combinational.
  generate
    for (genvar gi = 1; gi < RF_DEPTH; gi++) begin : g_rf
      logic [DATA_W-1:0] r_q;
      logic              w_we;

      assign w_we = ldRF && (fld_C == RF_IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_we) begin
          r_q <= r_rin;
        end
      end

      assign w_rf[gi] = r_q;
    end
  endgenerate

  assign w_a = w_rf[fld_A];
  assign w_b = w_rf[fld_B];

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a (w_a),
    .b (w_b),
    .op(alu_op),
    .r (w_r),
    .c (w_c)
  );

  // Loading R_in from data_in alone is not an ALU result, so flags hold.
  assign w_capture = (ldR_in && !selR_in) || ldR_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rin  <= '0;
      r_rout <= '0;
      r_cy   <= 1'b0;
      r_neg  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (ldR_in) begin
        r_rin <= selR_in ? data_in : w_r;
      end
      if (ldR_out) begin
        r_rout <= w_r;
      end
      if (w_capture) begin
        r_cy   <= w_c;
        r_neg  <= w_r[DATA_W-1];
        r_zero <= (w_r == '0);
      end
    end
  end

  assign data_out = r_rout;
  assign cy       = r_cy;
  assign neg      = r_neg;
  assign zero     = r_zero;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: each step queues the expected R_out/flags and
// the values are popped and compared just after the sampling edge.
module tb_datapath;
  import mps_pkg::*;

  localparam int DW = 8;

  typedef struct {
    string         tag;
    logic [DW-1:0] d;
    logic          cy;
    logic          neg;
    logic          zero;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [2:0]    fld_A, fld_B, fld_C;
  logic          ldRF, selR_in, ldR_in, ldR_out;
  logic [1:0]    alu_op;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          cy, neg, zero;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  datapath #(.DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fld_A   (fld_A),
    .fld_B   (fld_B),
    .fld_C   (fld_C),
    .ldRF    (ldRF),
    .selR_in (selR_in),
    .ldR_in  (ldR_in),
    .ldR_out (ldR_out),
    .alu_op  (alu_op),
    .data_in (data_in),
    .data_out(data_out),
    .cy      (cy),
    .neg     (neg),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [DW-1:0] d, input logic c_f,
                      input logic n_f, input logic z_f);
    exp_t e;
    e.tag = tag; e.d = d; e.cy = c_f; e.neg = n_f; e.zero = z_f;
    exp_q.push_back(e);
  endtask

  // Apply one control word across one rising edge, then check pending results.
  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input logic lrf, input logic sel, input logic lin,
                      input logic lout, input logic [1:0] op, input logic [DW-1:0] din);
    exp_t e;
    fld_A = a; fld_B = b; fld_C = c; ldRF = lrf; selR_in = sel;
    ldR_in = lin; ldR_out = lout; alu_op = op; data_in = din;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (data_out === e.d) else begin
        errors++;
        $error("FAIL %s data_out got %h expected %h", e.tag, data_out, e.d);
      end
      checks++;
      assert ({cy, neg, zero} === {e.cy, e.neg, e.zero}) else begin
        errors++;
        $error("FAIL %s flags(cy,neg,zero) got %b expected %b", e.tag,
               {cy, neg, zero}, {e.cy, e.neg, e.zero});
      end
    end
  endtask

  task automatic idle();
    step(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0);
  endtask

  task automatic load_reg(input logic [2:0] k, input logic [DW-1:0] v);
    step(3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, v);
    step(3'd0, 3'd0, k,    1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0);
  endtask

  // Read RF[k] through OR with RF[0] into R_out; flags follow from the value.
  task automatic read_rf(input string tag, input logic [2:0] k, input logic [DW-1:0] v);
    push(tag, v, 1'b0, v[DW-1], v == '0);
    step(k, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR, '0);
  endtask

  task automatic alu_out(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] op, input logic [DW-1:0] d,
                         input logic c_f, input logic n_f, input logic z_f);
    push(tag, d, c_f, n_f, z_f);
    step(a, b, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, op, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    fld_A = '0; fld_B = '0; fld_C = '0; ldRF = 1'b0; selR_in = 1'b0;
    ldR_in = 1'b0; ldR_out = 1'b0; alu_op = '0; data_in = '0;
    idle();
    idle();
    rst_n = 1'b1;
    push("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    idle();

    // Preload state and set flags, then reset mid-program with a load pending.
    for (int k = 1; k < 8; k++) load_reg(3'(k), 8'(8'hA0 + k));
    alu_out("preload_sub", 3'd1, 3'd2, ALU_SUB, 8'hFF, 1'b0, 1'b1, 1'b0);
    data_in = 8'h99;
    rst_n = 1'b0;
    push("reset_override", 8'h00, 1'b0, 1'b0, 1'b0);
    step(3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, ALU_ADD, 8'h99);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) read_rf($sformatf("reset_rf%0d", k), 3'(k), 8'h00);

    // Load and add.
    load_reg(3'd1, 8'h05);
    load_reg(3'd2, 8'h07);
    alu_out("add_basic", 3'd1, 3'd2, ALU_ADD, 8'h0C, 1'b0, 1'b0, 1'b0);

    // Carry and zero.
    load_reg(3'd1, 8'hFF);
    load_reg(3'd2, 8'h01);
    alu_out("add_carry", 3'd1, 3'd2, ALU_ADD, 8'h00, 1'b1, 1'b0, 1'b1);

    // Subtract with and without borrow.
    load_reg(3'd1, 8'h03);
    load_reg(3'd2, 8'h05);
    alu_out("sub_borrow", 3'd1, 3'd2, ALU_SUB, 8'hFE, 1'b0, 1'b1, 1'b0);
    alu_out("sub_noborrow", 3'd2, 3'd1, ALU_SUB, 8'h02, 1'b1, 1'b0, 1'b0);
    alu_out("sub_equal", 3'd1, 3'd1, ALU_SUB, 8'h00, 1'b1, 1'b0, 1'b1);

    // RF[0] discards writes; external loads leave flags alone.
    load_reg(3'd0, 8'h55);
    alu_out("rf0_add", 3'd0, 3'd0, ALU_ADD, 8'h00, 1'b0, 1'b0, 1'b1);
    push("flag_hold", 8'h00, 1'b0, 1'b0, 1'b1);
    step(3'd2, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD, 8'h80);
    push("flag_hold_idle", 8'h00, 1'b0, 1'b0, 1'b1);
    idle();

    // ldRF + ldR_in in one cycle; same-cycle read of RF[3] returns old value.
    load_reg(3'd3, 8'h5A);
    step(3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'h11);
    push("rdw_old", 8'h5A, 1'b0, 1'b0, 1'b0);
    step(3'd3, 3'd0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, ALU_OR, 8'h22);
    read_rf("rf_got_old_rin", 3'd3, 8'h11);
    step(3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0);
    read_rf("rin_new", 3'd4, 8'h22);

    // AND/OR, and ldR_in (ALU path) with ldR_out capturing the same result.
    alu_out("and_zero", 3'd3, 3'd4, ALU_AND, 8'h00, 1'b0, 1'b0, 1'b1);
    alu_out("or_val", 3'd3, 3'd4, ALU_OR, 8'h33, 1'b0, 1'b0, 1'b0);
    load_reg(3'd1, 8'hC0);
    load_reg(3'd2, 8'h50);
    push("dual_capture", 8'h10, 1'b1, 1'b0, 1'b0);
    step(3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_ADD, 8'hEE);
    step(3'd0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0);
    read_rf("rin_alu_path", 3'd5, 8'h10);

    // All-zero control word changes nothing.
    alu_out("pre_idle", 3'd1, 3'd0, ALU_OR, 8'hC0, 1'b0, 1'b1, 1'b0);
    push("idle_hold", 8'hC0, 1'b0, 1'b1, 1'b0);
    idle();
    read_rf("idle_rf5", 3'd5, 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
